quad_lut_sweeper: RTL and testbench

- Sequential front-end for the quadratic function LUT.
- On `start` it steps a signed x over a programmed range and drives each x onto the LUT's `xq` input.
- It captures the LUT's combinational `yq_lut` and `yq_fun` results and streams `{x, y, mismatch}` downstream over a valid/ready interface.
- It counts disagreements between the table and the direct evaluation, giving the design a self-checking sweep of the LUT contents.

---
 rtl/quad_lut_sweeper.sv | 121 ++++++++++++
 tb/tb_quad_lut_sweeper.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/quad_lut_sweeper.sv
// Sequential sweeper for a quadratic-function LUT: steps x across a programmed
// range, captures table/direct results, streams {x, y, mismatch} and counts disagreements.
module quad_lut_sweeper #(
    parameter int W_X = 4,
    parameter int W_Y = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic signed [W_X-1:0] x_first,
    input  logic signed [W_X-1:0] x_last,
    output logic signed [W_X-1:0] xq,
    input  logic signed [W_Y-1:0] yq_lut,
    input  logic signed [W_Y-1:0] yq_fun,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic signed [W_X-1:0] m_x,
    output logic signed [W_Y-1:0] m_y,
    output logic                  m_mismatch,
    output logic                  busy,
    output logic                  done,
    output logic [W_X:0]          err_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic signed [W_X-1:0] X_ONE   = {{(W_X-1){1'b0}}, 1'b1};
    localparam logic        [W_X:0]   ERR_ONE = {{W_X{1'b0}}, 1'b1};

    state_t                  r_state;
    logic signed [W_X-1:0]   r_x_cur;
    logic signed [W_X-1:0]   r_x_end;
    logic                    r_m_valid;
    logic signed [W_X-1:0]   r_m_x;
    logic signed [W_Y-1:0]   r_m_y;
    logic                    r_m_mismatch;
    logic                    r_busy;
    logic                    r_done;
    logic [W_X:0]            r_err_count;

    logic                    w_slot_free;
    logic                    w_mismatch;
    logic                    w_at_end;
    logic                    w_accept;

    // The output register can take a new sample if empty or being drained this cycle.
    assign w_slot_free = !r_m_valid || m_ready;
    assign w_accept    = r_m_valid && m_ready;
    assign w_mismatch  = (yq_lut != yq_fun);
    assign w_at_end    = (r_x_cur == r_x_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_x_cur      <= '0;
            r_x_end      <= '0;
            r_m_valid    <= 1'b0;
            r_m_x        <= '0;
            r_m_y        <= '0;
            r_m_mismatch <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x_cur     <= x_first;
                        r_x_end     <= x_last;
                        r_err_count <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_slot_free) begin
                        r_m_x        <= r_x_cur;
                        r_m_y        <= yq_lut;
                        r_m_mismatch <= w_mismatch;
                        r_m_valid    <= 1'b1;
                        if (w_mismatch) begin
                            r_err_count <= r_err_count + ERR_ONE;
                        end
                        // x wraps modulo 2^W_X, so a full-range sweep is legal.
                        if (w_at_end) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_x_cur <= r_x_cur + X_ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_accept) begin
                        r_m_valid <= 1'b0;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign xq         = r_x_cur;
    assign m_valid    = r_m_valid;
    assign m_x        = r_m_x;
    assign m_y        = r_m_y;
    assign m_mismatch = r_m_mismatch;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_quad_lut_sweeper.sv
// Self-checking bench for quad_lut_sweeper with a behavioural y = x^2 + 10x - 10 LUT,
// per-x mismatch injection, directed and randomized sweeps, backpressure and reset abort.
module tb_quad_lut_sweeper;

    localparam int W_X = 4;
    localparam int W_Y = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic signed [W_X-1:0] x_first;
    logic signed [W_X-1:0] x_last;
    logic signed [W_X-1:0] xq;
    logic signed [W_Y-1:0] yq_lut;
    logic signed [W_Y-1:0] yq_fun;
    logic                  m_valid;
    logic                  m_ready;
    logic signed [W_X-1:0] m_x;
    logic signed [W_Y-1:0] m_y;
    logic                  m_mismatch;
    logic                  busy;
    logic                  done;
    logic [W_X:0]          err_count;

    logic [15:0]           inj_mask;
    logic [3:0]            xq_idx;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    quad_lut_sweeper #(.W_X(W_X), .W_Y(W_Y)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .x_first    (x_first),
        .x_last     (x_last),
        .xq         (xq),
        .yq_lut     (yq_lut),
        .yq_fun     (yq_fun),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_x        (m_x),
        .m_y        (m_y),
        .m_mismatch (m_mismatch),
        .busy       (busy),
        .done       (done),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    function automatic int lut_f(input int x);
        return x * x + 10 * x - 10;
    endfunction

    // xq XOR 8 maps signed x in -8..7 onto mask index x+8.
    assign xq_idx = xq ^ 4'h8;
    always_comb begin
        yq_lut = W_Y'(lut_f(int'(xq)));
        yq_fun = yq_lut + (inj_mask[xq_idx] ? 8'sd1 : 8'sd0);
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_xq"}, $signed(xq), 0);
        check({pfx, "_m_valid"}, m_valid, 0);
        check({pfx, "_m_x"}, $signed(m_x), 0);
        check({pfx, "_m_y"}, $signed(m_y), 0);
        check({pfx, "_m_mismatch"}, m_mismatch, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_err_count"}, err_count, 0);
    endtask

    // Runs one sweep from a negedge; ready_mode 0=always, 1=pattern 1,0,0, 2=random.
    // glitch keeps start high one cycle into RUN; abort_after>0 resets after that many handshakes.
    task automatic run_sweep(input int first, input int last, input int ready_mode,
                             input bit glitch, input int abort_after, input string name);
        int exp_x[$];
        int exp_mis[$];
        int n;
        int exp_err;
        int hs_count;
        bit finished;
        bit hs;
        bit stall;
        logic signed [W_X-1:0] s_x, s_xq;
        logic signed [W_Y-1:0] s_y;
        logic s_mis;

        n = ((last - first) % 16 + 16) % 16 + 1;
        exp_err = 0;
        for (int i = 0; i < n; i++) begin
            int x;
            x = ((first + i + 8) % 16 + 16) % 16 - 8;
            exp_x.push_back(x);
            exp_mis.push_back(int'(inj_mask[x + 8]));
            exp_err += int'(inj_mask[x + 8]);
        end

        x_first = W_X'(first);
        x_last  = W_X'(last);
        start   = 1'b1;
        m_ready = 1'b0;
        @(negedge clk);
        if (!glitch) start = 1'b0;
        check({name, "_start_busy"}, busy, 1);
        check({name, "_start_xq"}, $signed(xq), first);
        check({name, "_start_err_clr"}, err_count, 0);
        check({name, "_start_no_done"}, done, 0);

        hs_count = 0;
        finished = 1'b0;
        for (int it = 1; it <= 400; it++) begin
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((it - 1) % 3 == 0);
                default: m_ready = ($urandom_range(3, 0) != 0);
            endcase
            hs    = m_valid && m_ready;
            stall = m_valid && !m_ready;
            s_x = m_x; s_y = m_y; s_mis = m_mismatch; s_xq = xq;
            if (hs) begin
                check({name, "_no_extra"}, exp_x.size() > 0, 1);
                if (exp_x.size() > 0) begin
                    $display("%s: sample x=%0d y=%0d mis=%0d", name, m_x, m_y, m_mismatch);
                    check({name, "_m_x"}, $signed(m_x), exp_x[0]);
                    check({name, "_m_y"}, $signed(m_y), lut_f(exp_x[0]));
                    check({name, "_m_mismatch"}, m_mismatch, exp_mis[0]);
                    void'(exp_x.pop_front());
                    void'(exp_mis.pop_front());
                end
                hs_count++;
            end
            @(negedge clk);
            start = 1'b0;
            if (stall) begin
                check({name, "_hold_valid"}, m_valid, 1);
                check({name, "_hold_x"}, $signed(m_x), $signed(s_x));
                check({name, "_hold_y"}, $signed(m_y), $signed(s_y));
                check({name, "_hold_mis"}, m_mismatch, s_mis);
                check({name, "_hold_xq"}, $signed(xq), $signed(s_xq));
            end
            if (abort_after > 0 && hs_count == abort_after) begin
                #2 rst_n = 1'b0;
                #1 check_reset({name, "_async"});
                @(negedge clk);
                check_reset({name, "_held"});
                rst_n = 1'b1;
                return;
            end
            if (hs && exp_x.size() == 0) begin
                check({name, "_done"}, done, 1);
                check({name, "_busy_off"}, busy, 0);
                check({name, "_err_count"}, err_count, exp_err);
                if (ready_mode == 0) check({name, "_cycles"}, it, n + 1);
                finished = 1'b1;
                break;
            end else begin
                check({name, "_done_early"}, done, 0);
            end
        end
        check({name, "_finished"}, finished, 1);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        m_ready  = 1'b0;
        x_first  = '0;
        x_last   = '0;
        inj_mask = '0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(-1, 2, 0, 1'b0, 0, "basic");
        run_sweep(0, -1, 0, 1'b0, 0, "wrap");
        run_sweep(-1, 2, 1, 1'b0, 0, "backpressure");

        inj_mask = 16'(1) << 9;
        run_sweep(-1, 2, 0, 1'b0, 0, "inject");
        inj_mask = '0;

        run_sweep(3, 3, 0, 1'b1, 0, "single");
        @(negedge clk);
        check("single_glitch_ignored", busy, 0);

        run_sweep(0, -1, 0, 1'b0, 2, "abort");
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
            check("abort_no_resume", busy, 0);
        end
        run_sweep(-1, 2, 0, 1'b0, 0, "post_abort");

        for (int r = 0; r < 8; r++) begin
            int f;
            int l;
            f = int'($urandom_range(15, 0)) - 8;
            l = int'($urandom_range(15, 0)) - 8;
            inj_mask = 16'($urandom);
            run_sweep(f, l, 2, r[0], 0, "random");
        end
        inj_mask = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
